instr_rom_fetch: RTL and testbench

INSTR_ROM_FETCH -- requirements
Module: instr_rom_fetch

---
 rtl/instr_rom_fetch.sv | 144 ++++++++++++++
 tb/tb_instr_rom_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_rom_fetch.sv
// ----------------------------------------------------------------------------
// instr_rom_fetch
//
// Instruction ROM with a program-load write port and a LATENCY-stage fetch
// pipeline. Each fetch reads one word at the cycle it is accepted. The result
// then moves through the stage registers. The last stage drives the response
// outputs directly.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous active-high reset
//   req_valid  in   1       fetch request present
//   req_ready  out  1       request may be accepted this cycle
//   address    in   32      byte address of the fetch
//   flush      in   1       drop every in-flight fetch (taken branch)
//   rsp_valid  out  1       response word valid
//   rsp_ready  in   1       consumer takes the response this cycle
//   out        out  DATA_W  fetched instruction
//   halt       out  1       response address was out of range
//   fault      out  1       response address was misaligned
//   load_en    in   1       program-load write strobe
//   load_addr  in   AW      word index written
//   load_data  in   DATA_W  word written
// ----------------------------------------------------------------------------
module instr_rom_fetch #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                LATENCY   = 1,
    parameter logic [DATA_W-1:0] HALT_WORD = '1,
    localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       address,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] out,
    output logic              halt,
    output logic              fault,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data
);

    // Instruction storage. Reset does not clear it.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Per-stage state. Stage LATENCY-1 is the response stage.
    logic              vld_q   [LATENCY];
    logic              vld_d   [LATENCY];
    logic [DATA_W-1:0] data_q  [LATENCY];
    logic [DATA_W-1:0] data_d  [LATENCY];
    logic              halt_q  [LATENCY];
    logic              halt_d  [LATENCY];
    logic              fault_q [LATENCY];
    logic              fault_d [LATENCY];

    logic [AW-1:0]     rd_idx_s;
    logic              oor_s;
    logic              mis_s;
    logic              advance_s;
    logic              accept_s;
    logic [DATA_W-1:0] rd_word_s;

    assign rd_idx_s  = address[AW+1:2];
    // Any set bit above the word-index field means the address is >= 4*DEPTH.
    assign oor_s     = |address[31:AW+2];
    assign mis_s     = |address[1:0];
    assign rd_word_s = mem_q[rd_idx_s];

    // The pipeline moves when the consumer takes the response or the
    // response slot is empty.
    assign advance_s = rsp_ready || !vld_q[LATENCY-1];
    assign req_ready = advance_s && !reset;
    assign accept_s  = req_valid && req_ready && !flush;

    // Program-load write port. The read above sees the pre-write contents,
    // so a same-cycle load to the fetched index returns the old word.
    always_ff @(posedge clk) begin
        if (load_en && !reset) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Next-state logic for the stages: flush, shift, or hold.
    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        halt_d  = halt_q;
        fault_d = fault_q;
        if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_d[i]   = 1'b0;
                data_d[i]  = '0;
                halt_d[i]  = 1'b0;
                fault_d[i] = 1'b0;
            end
        end else if (advance_s) begin
            // Bubbles enter with all fields zero. Response outputs are
            // therefore zero whenever rsp_valid is low.
            vld_d[0]   = accept_s;
            data_d[0]  = !accept_s ? '0 : (oor_s ? HALT_WORD : rd_word_s);
            halt_d[0]  = accept_s && oor_s;
            fault_d[0] = accept_s && mis_s && !oor_s;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i]   = vld_q[i-1];
                data_d[i]  = data_q[i-1];
                halt_d[i]  = halt_q[i-1];
                fault_d[i] = fault_q[i-1];
            end
        end else begin
            vld_d   = vld_q;
            data_d  = data_q;
            halt_d  = halt_q;
            fault_d = fault_q;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]   <= 1'b0;
                data_q[i]  <= '0;
                halt_q[i]  <= 1'b0;
                fault_q[i] <= 1'b0;
            end
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            halt_q  <= halt_d;
            fault_q <= fault_d;
        end
    end

    assign rsp_valid = vld_q[LATENCY-1];
    assign out       = data_q[LATENCY-1];
    assign halt      = halt_q[LATENCY-1];
    assign fault     = fault_q[LATENCY-1];

endmodule

// File: tb/tb_instr_rom_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_rom_fetch
//
// Directed bench for instr_rom_fetch. It drives two instances from the same
// stimulus:
//   - u_dut1 uses LATENCY=1.
//   - u_dut3 uses LATENCY=3.
// Each scenario checks the instance its timing was written for.
// ----------------------------------------------------------------------------
module tb_instr_rom_fetch;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] address;
    logic        flush;
    logic        rsp_ready;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;

    logic        req_ready1, rsp_valid1, halt1, fault1;
    logic [31:0] out1;
    logic        req_ready3, rsp_valid3, halt3, fault3;
    logic [31:0] out3;

    logic [31:0] w [8];
    int          n_checks;
    int          n_errors;

    instr_rom_fetch #(.DATA_W(32), .DEPTH(64), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
        .address(address), .flush(flush), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready), .out(out1), .halt(halt1), .fault(fault1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    instr_rom_fetch #(.DATA_W(32), .DEPTH(64), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
        .address(address), .flush(flush), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready), .out(out3), .halt(halt3), .fault(fault3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_checks++; if (rsp_valid1 !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid1: got %b expected 0", rsp_valid1); end
        n_checks++; if (out1 !== 32'h0) begin n_errors++; $display("FAIL reset_out1: got %h expected 00000000", out1); end
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid3: got %b expected 0", rsp_valid3); end
        n_checks++; if (out3 !== 32'h0) begin n_errors++; $display("FAIL reset_out3: got %h expected 00000000", out3); end
        n_checks++; if ({halt3, fault3} !== 2'b00) begin n_errors++; $display("FAIL reset_halt_fault3: got %b expected 00", {halt3, fault3}); end
        n_checks++; if (req_ready3 !== 1'b0) begin n_errors++; $display("FAIL reset_req_ready3: got %b expected 0", req_ready3); end
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready1 !== 1'b1) begin n_errors++; $display("FAIL post_reset_req_ready1: got %b expected 1", req_ready1); end
    endtask

    task automatic load_program();
        for (int i = 0; i < 8; i++) begin
            load_en   = 1'b1;
            load_addr = 6'(i);
            load_data = w[i];
            step();
        end
        load_en = 1'b0;
    endtask

    task automatic test_stream_lat1();
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            address   = 32'(4 * i);
            #1;
            n_checks++; if (req_ready1 !== 1'b1) begin n_errors++; $display("FAIL stream_req_ready idx %0d: got %b expected 1", i, req_ready1); end
            step();
            n_checks++; if (rsp_valid1 !== 1'b1) begin n_errors++; $display("FAIL stream_rsp_valid idx %0d: got %b expected 1", i, rsp_valid1); end
            n_checks++; if (out1 !== w[i]) begin n_errors++; $display("FAIL stream_out idx %0d: got %h expected %h", i, out1, w[i]); end
        end
        req_valid = 1'b0;
        step();
        n_checks++; if (rsp_valid1 !== 1'b0) begin n_errors++; $display("FAIL stream_idle_rsp_valid: got %b expected 0", rsp_valid1); end
        repeat (3) step();
    endtask

    task automatic test_stall_lat3();
        int sent;
        int rcv;
        int stall_cnt;
        bit seen_first;
        sent = 0; rcv = 0; stall_cnt = 0; seen_first = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            if (rsp_valid3 && !seen_first) begin
                seen_first = 1'b1;
                stall_cnt  = 5;
            end
            rsp_ready = (stall_cnt == 0);
            req_valid = (sent < 6);
            address   = 32'(4 * sent);
            #1;
            if (stall_cnt > 0) begin
                n_checks++; if (req_ready3 !== 1'b0) begin n_errors++; $display("FAIL stall_req_ready cyc %0d: got %b expected 0", cyc, req_ready3); end
            end
            if (rsp_valid3) begin
                n_checks++; if (out3 !== w[rcv]) begin n_errors++; $display("FAIL stall_order rsp %0d: got %h expected %h", rcv, out3, w[rcv]); end
                if (rsp_ready) rcv++;
            end
            if (req_valid && req_ready3) sent++;
            if (stall_cnt > 0) stall_cnt--;
            step();
        end
        n_checks++; if (rcv !== 6) begin n_errors++; $display("FAIL stall_count: got %0d responses expected 6", rcv); end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) step();
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL stall_no_dup: got %b expected 0", rsp_valid3); end
    endtask

    task automatic test_halt_fault();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        address   = 32'h0000_0100;
        step();
        n_checks++; if (out1 !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL oor_out: got %h expected ffffffff", out1); end
        n_checks++; if ({rsp_valid1, halt1, fault1} !== 3'b110) begin n_errors++; $display("FAIL oor_flags: got %b expected 110", {rsp_valid1, halt1, fault1}); end
        address = 32'h0000_0006;
        step();
        n_checks++; if (out1 !== w[1]) begin n_errors++; $display("FAIL mis_out: got %h expected %h", out1, w[1]); end
        n_checks++; if ({rsp_valid1, halt1, fault1} !== 3'b101) begin n_errors++; $display("FAIL mis_flags: got %b expected 101", {rsp_valid1, halt1, fault1}); end
        address = 32'h0000_0102;
        step();
        n_checks++; if (out1 !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL oor_mis_out: got %h expected ffffffff", out1); end
        n_checks++; if ({rsp_valid1, halt1, fault1} !== 3'b110) begin n_errors++; $display("FAIL oor_mis_flags: got %b expected 110", {rsp_valid1, halt1, fault1}); end
        req_valid = 1'b0;
        step();
        n_checks++; if ({rsp_valid1, halt1, fault1} !== 3'b000) begin n_errors++; $display("FAIL idle_flags: got %b expected 000", {rsp_valid1, halt1, fault1}); end
        n_checks++; if ({rsp_valid3, halt3, fault3} !== 3'b101) begin n_errors++; $display("FAIL mis_flags3: got %b expected 101", {rsp_valid3, halt3, fault3}); end
        n_checks++; if (out3 !== w[1]) begin n_errors++; $display("FAIL mis_out3: got %h expected %h", out3, w[1]); end
        repeat (3) step();
    endtask

    task automatic test_flush();
        // Two requests accepted. A third request arrives together with flush.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        address   = 32'h0;
        step();
        address   = 32'h4;
        step();
        address   = 32'h8;
        flush     = 1'b1;
        step();
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL flush1_next: got %b expected 0", rsp_valid3); end
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL flush1_quiet cyc %0d: got %b expected 0", i, rsp_valid3); end
        end
        // Three requests fill the stalled pipe. A fourth arrives with flush.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address = 32'(4 * i);
            step();
        end
        n_checks++; if (rsp_valid3 !== 1'b1 || out3 !== w[0]) begin n_errors++; $display("FAIL flush2_full: got %b/%h expected 1/%h", rsp_valid3, out3, w[0]); end
        address = 32'hC;
        flush   = 1'b1;
        step();
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL flush2_next: got %b expected 0", rsp_valid3); end
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL flush2_quiet cyc %0d: got %b expected 0", i, rsp_valid3); end
        end
    endtask

    task automatic test_read_before_write();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        address   = 32'h8;
        load_en   = 1'b1;
        load_addr = 6'd2;
        load_data = 32'hDEAD_BEEF;
        step();
        n_checks++; if (out1 !== w[2]) begin n_errors++; $display("FAIL rbw_old: got %h expected %h", out1, w[2]); end
        load_en = 1'b0;
        w[2]    = 32'hDEAD_BEEF;
        step();
        n_checks++; if (out1 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rbw_new: got %h expected deadbeef", out1); end
        req_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        address   = 32'h0000_0100;
        step();
        address   = 32'h0000_0006;
        step();
        // Reset with two fetches in flight. A load attempted during reset is ignored.
        reset     = 1'b1;
        address   = 32'h0;
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = 32'h1234_5678;
        #1;
        n_checks++; if (req_ready3 !== 1'b0) begin n_errors++; $display("FAIL midrst_req_ready: got %b expected 0", req_ready3); end
        step();
        n_checks++; if ({rsp_valid3, halt3, fault3} !== 3'b000) begin n_errors++; $display("FAIL midrst_flags: got %b expected 000", {rsp_valid3, halt3, fault3}); end
        n_checks++; if (out3 !== 32'h0) begin n_errors++; $display("FAIL midrst_out: got %h expected 00000000", out3); end
        reset   = 1'b0;
        load_en = 1'b0;
        #1;
        n_checks++; if (req_ready3 !== 1'b1) begin n_errors++; $display("FAIL postrst_req_ready: got %b expected 1", req_ready3); end
        step();
        req_valid = 1'b0;
        step();
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL postrst_early: got %b expected 0", rsp_valid3); end
        step();
        n_checks++; if (rsp_valid3 !== 1'b1 || out3 !== w[0]) begin n_errors++; $display("FAIL postrst_word: got %b/%h expected 1/%h", rsp_valid3, out3, w[0]); end
        step();
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_errors++; $display("FAIL postrst_no_dup: got %b expected 0", rsp_valid3); end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        address   = 32'h0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        load_addr = 6'd0;
        load_data = 32'h0;
        w[0] = 32'h0030_0093;
        w[1] = 32'h0040_0113;
        w[2] = 32'h0050_0193;
        w[3] = 32'h0060_0213;
        w[4] = 32'h0070_0293;
        w[5] = 32'h0080_0313;
        w[6] = 32'h0090_0393;
        w[7] = 32'h00A0_0413;

        test_reset();
        load_program();
        test_stream_lat1();
        test_stall_lat3();
        test_halt_fault();
        test_flush();
        test_read_before_write();
        test_reset_midflight();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
